serial_addr_decoder_n: RTL and testbench

//  Parametrised successor of the 3-target serial address decoder; sits between the bus arbiter's serial line and target mux.

---
 rtl/serial_bus_pkg.sv | 25 ++
 rtl/serial_addr_decoder_n.sv | 170 +++++++++++++++++
 tb/tb_serial_addr_decoder_n.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_bus_pkg.sv
// Shared types and defaults for the serial address decoder.
//   dec_state_e   : decoder FSM states (ADDR = collecting address bits,
//                   DATA_HOLD = a target is selected for one data frame)
//   DEF_TGT_BASE  : default 3-target base map, index 0 in the LSBs
//   DEF_TGT_MASK  : default 3-target compare masks (1 = bit compared)
//   addr_match()  : window compare; callers zero-extend to MATCH_W bits
package serial_bus_pkg;

  typedef enum logic {
    ADDR      = 1'b0,
    DATA_HOLD = 1'b1
  } dec_state_e;

  localparam int MATCH_W = 32;

  localparam logic [2:0][15:0] DEF_TGT_BASE = {16'h8000, 16'h4000, 16'h0000};
  localparam logic [2:0][15:0] DEF_TGT_MASK = {16'hF000, 16'hC000, 16'hF800};

  function automatic logic addr_match(input logic [MATCH_W-1:0] addr,
                                      input logic [MATCH_W-1:0] base,
                                      input logic [MATCH_W-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/serial_addr_decoder_n.sv
// Serial address decoder with N_TGT base/mask windows.
// Shifts in an LSB-first address, picks the lowest-index matching window and
// holds a one-hot select for one DATA_W-bit data frame.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   bus_data_in        : serial bit
//   bus_data_in_valid  : bit qualifier
//   bus_mode           : 1 = data phase, 0 = address phase
//   split              : split target replying; forces select to SPLIT_TGT
//   tgt_valid [N_TGT]  : one-hot target enable
//   sel [SEL_W]        : encoded index of the selected target
//   decode_err         : one-cycle pulse when a full address hits no window
//   busy               : high while a target is held
//   dbg_state          : current FSM state (0 = ADDR, 1 = DATA_HOLD)
//
// Transfer semantics: there is no back-pressure. A bit is consumed on every
// rising clk edge where bus_data_in_valid is 1; bus_data_in and bus_mode are
// only meaningful in that cycle. With valid low nothing advances.
module serial_addr_decoder_n
  import serial_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int N_TGT  = 3,
  parameter logic [N_TGT-1:0][ADDR_W-1:0] TGT_BASE = DEF_TGT_BASE,
  parameter logic [N_TGT-1:0][ADDR_W-1:0] TGT_MASK = DEF_TGT_MASK,
  parameter int SPLIT_TGT = 2,
  localparam int SEL_W = $clog2(N_TGT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_data_in,
  input  logic             bus_data_in_valid,
  input  logic             bus_mode,
  input  logic             split,
  output logic [N_TGT-1:0] tgt_valid,
  output logic [SEL_W-1:0] sel,
  output logic             decode_err,
  output logic             busy,
  output logic             dbg_state
);

  localparam int ACNT_W = $clog2(ADDR_W + 1);
  localparam int DCNT_W = $clog2(DATA_W + 1);
  localparam int AIDX_W = $clog2(ADDR_W);

  dec_state_e        state, state_next;
  logic [ACNT_W-1:0] addr_cnt, addr_cnt_next;
  logic [DCNT_W-1:0] data_cnt, data_cnt_next;
  logic [ADDR_W-1:0] shift_q, shift_next;
  logic [N_TGT-1:0]  held_oh, held_oh_next;
  logic [SEL_W-1:0]  held_sel, held_sel_next;
  logic              decode_err_next;

  logic [ADDR_W-1:0] addr_full;
  logic [N_TGT-1:0]  win_hit;
  logic [SEL_W-1:0]  hit_sel;
  logic              hit_any;
  logic              last_addr_bit;
  logic              last_data_bit;

  // Address including the bit arriving this cycle, so the final compare
  // happens in the same cycle as the last bit.
  always_comb begin
    addr_full = shift_q;
    addr_full[addr_cnt[AIDX_W-1:0]] = bus_data_in;
  end

  for (genvar i = 0; i < N_TGT; i++) begin : g_win
    assign win_hit[i] = addr_match(MATCH_W'(addr_full),
                                   MATCH_W'(TGT_BASE[i]),
                                   MATCH_W'(TGT_MASK[i]));
  end

  // Scan from the top down so the lowest matching index ends up in hit_sel.
  always_comb begin
    hit_any = |win_hit;
    hit_sel = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if (win_hit[i]) hit_sel = SEL_W'(i);
    end
  end

  assign last_addr_bit = (addr_cnt == ACNT_W'(ADDR_W - 1));
  assign last_data_bit = (data_cnt == DCNT_W'(DATA_W - 1));

  always_comb begin
    state_next      = state;
    addr_cnt_next   = addr_cnt;
    data_cnt_next   = data_cnt;
    shift_next      = shift_q;
    held_oh_next    = held_oh;
    held_sel_next   = held_sel;
    decode_err_next = 1'b0;

    case (state)
      ADDR: begin
        if (bus_data_in_valid && !bus_mode) begin
          if (last_addr_bit) begin
            addr_cnt_next = '0;
            shift_next    = '0;
            if (hit_any) begin
              state_next    = DATA_HOLD;
              held_oh_next  = N_TGT'(1) << hit_sel;
              held_sel_next = hit_sel;
              data_cnt_next = '0;
            end else begin
              decode_err_next = 1'b1;
            end
          end else begin
            shift_next    = addr_full;
            addr_cnt_next = addr_cnt + ACNT_W'(1);
          end
        end else if (bus_data_in_valid && bus_mode && addr_cnt != '0) begin
          // Data-phase bit arrived mid-address: drop the partial address.
          addr_cnt_next = '0;
          shift_next    = '0;
        end
      end

      DATA_HOLD: begin
        if (bus_data_in_valid) begin
          if (bus_mode) begin
            if (last_data_bit) begin
              state_next    = ADDR;
              held_oh_next  = '0;
              held_sel_next = '0;
              data_cnt_next = '0;
            end else begin
              data_cnt_next = data_cnt + DCNT_W'(1);
            end
          end else begin
            // Address bits while held restart the frame count only.
            data_cnt_next = '0;
          end
        end
      end

      default: state_next = ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ADDR;
      addr_cnt   <= '0;
      data_cnt   <= '0;
      shift_q    <= '0;
      held_oh    <= '0;
      held_sel   <= '0;
      decode_err <= 1'b0;
    end else begin
      state      <= state_next;
      addr_cnt   <= addr_cnt_next;
      data_cnt   <= data_cnt_next;
      shift_q    <= shift_next;
      held_oh    <= held_oh_next;
      held_sel   <= held_sel_next;
      decode_err <= decode_err_next;
    end
  end

  // Split override is combinational and independent of the FSM.
  assign tgt_valid = split ? (N_TGT'(1) << SPLIT_TGT) : held_oh;
  assign sel       = split ? SEL_W'(SPLIT_TGT) : held_sel;
  assign busy      = (state == DATA_HOLD);
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_addr_decoder_n.sv
// Bench for serial_addr_decoder_n: a default 3-target instance and a 4-target
// instance share one stimulus stream. Every cycle both are compared with a
// transaction-level reference model; fixed vectors and hand sequences add
// constant expectations for the documented corner cases.
module tb_serial_addr_decoder_n;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic din = 1'b0;
  logic vld = 1'b0;
  logic mode = 1'b1;
  logic split = 1'b0;

  logic [2:0] tgt3;
  logic [1:0] sel3;
  logic       err3, busy3, dbg3;
  logic [3:0] tgt4;
  logic [1:0] sel4;
  logic       err4, busy4, dbg4;

  serial_addr_decoder_n dut3 (
    .clk(clk), .rst(rst), .bus_data_in(din), .bus_data_in_valid(vld),
    .bus_mode(mode), .split(split), .tgt_valid(tgt3), .sel(sel3),
    .decode_err(err3), .busy(busy3), .dbg_state(dbg3)
  );

  serial_addr_decoder_n #(
    .N_TGT(4),
    .TGT_BASE({16'hC000, 16'h8000, 16'h4000, 16'h0000}),
    .TGT_MASK({16'hC000, 16'hF000, 16'hC000, 16'hF800})
  ) dut4 (
    .clk(clk), .rst(rst), .bus_data_in(din), .bus_data_in_valid(vld),
    .bus_mode(mode), .split(split), .tgt_valid(tgt4), .sel(sel4),
    .decode_err(err4), .busy(busy4), .dbg_state(dbg4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an address is a number built from bits, a selected
  // target is an index (-1 = none), a frame is a count of data bits.
  int w_n[2];
  int w_base[2][4];
  int w_mask[2][4];
  int m_bits[2];
  int m_addr[2];
  int m_tgt[2];
  int m_data[2];
  int m_err[2];

  function automatic int find_tgt(input int k, input int a);
    for (int i = 0; i < w_n[k]; i++)
      if ((a & w_mask[k][i]) == w_base[k][i]) return i;
    return -1;
  endfunction

  task automatic model_step(input int k, input bit r, input bit v, input bit md, input bit b);
    int t;
    m_err[k] = 0;
    if (r) begin
      m_bits[k] = 0; m_addr[k] = 0; m_tgt[k] = -1; m_data[k] = 0;
    end else if (m_tgt[k] < 0) begin
      if (v && !md) begin
        m_addr[k] += int'(b) << m_bits[k];
        m_bits[k]++;
        if (m_bits[k] == ADDR_W) begin
          t = find_tgt(k, m_addr[k]);
          if (t >= 0) begin
            m_tgt[k] = t;
            m_data[k] = 0;
          end else begin
            m_err[k] = 1;
          end
          m_bits[k] = 0;
          m_addr[k] = 0;
        end
      end else if (v && md) begin
        m_bits[k] = 0;
        m_addr[k] = 0;
      end
    end else if (v) begin
      if (md) begin
        m_data[k]++;
        if (m_data[k] == DATA_W) begin
          m_tgt[k] = -1;
          m_data[k] = 0;
        end
      end else begin
        m_data[k] = 0;
      end
    end
  endtask

  // scoreboard: compare both instances against the model
  task automatic compare_model();
    int et, es;
    for (int k = 0; k < 2; k++) begin
      if (split) begin
        et = 4; es = 2;
      end else if (m_tgt[k] >= 0) begin
        et = 1 << m_tgt[k]; es = m_tgt[k];
      end else begin
        et = 0; es = 0;
      end
      if (k == 0) begin
        chk("m3_tgt", int'(tgt3), et);
        chk("m3_sel", int'(sel3), es);
        chk("m3_err", int'(err3), m_err[0]);
        chk("m3_busy", int'(busy3), int'(m_tgt[0] >= 0));
      end else begin
        chk("m4_tgt", int'(tgt4), et);
        chk("m4_sel", int'(sel4), es);
        chk("m4_err", int'(err4), m_err[1]);
        chk("m4_busy", int'(busy4), int'(m_tgt[1] >= 0));
      end
    end
  endtask

  // driver tasks: inputs change at negedge, outputs checked at next negedge
  task automatic step(input bit r, input bit v, input bit md, input bit b);
    rst = r; vld = v; mode = md; din = b;
    @(posedge clk);
    model_step(0, r, v, md, b);
    model_step(1, r, v, md, b);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_addr(input logic [15:0] a);
    for (int i = 0; i < ADDR_W; i++) step(1'b0, 1'b1, 1'b0, a[i]);
  endtask

  task automatic send_data(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'(($urandom_range(0, 1))));
  endtask

  typedef struct {
    logic [15:0] addr;
    int tgt3; int sel3; int err3;
    int tgt4; int sel4; int err4;
  } vec_t;

  vec_t vecs[11];

  initial begin
    w_n[0] = 3; w_n[1] = 4;
    w_base[0] = '{32'h0000, 32'h4000, 32'h8000, 32'h0};
    w_mask[0] = '{32'hF800, 32'hC000, 32'hF000, 32'h0};
    w_base[1] = '{32'h0000, 32'h4000, 32'h8000, 32'hC000};
    w_mask[1] = '{32'hF800, 32'hC000, 32'hF000, 32'hC000};
    for (int k = 0; k < 2; k++) begin
      m_bits[k] = 0; m_addr[k] = 0; m_tgt[k] = -1; m_data[k] = 0; m_err[k] = 0;
    end

    //            addr       t3 s3 e3  t4 s4 e4
    vecs[0]  = '{16'h0123,   1, 0, 0,  1, 0, 0};
    vecs[1]  = '{16'h4ABC,   2, 1, 0,  2, 1, 0};
    vecs[2]  = '{16'hC000,   0, 0, 1,  8, 3, 0};
    vecs[3]  = '{16'h8001,   4, 2, 0,  4, 2, 0};
    vecs[4]  = '{16'h0000,   1, 0, 0,  1, 0, 0};
    vecs[5]  = '{16'h07FF,   1, 0, 0,  1, 0, 0};
    vecs[6]  = '{16'h0800,   0, 0, 1,  0, 0, 1};
    vecs[7]  = '{16'h7FFF,   2, 1, 0,  2, 1, 0};
    vecs[8]  = '{16'h8FFF,   4, 2, 0,  4, 2, 0};
    vecs[9]  = '{16'h9000,   0, 0, 1,  0, 0, 1};
    vecs[10] = '{16'hFFFF,   0, 0, 1,  8, 3, 0};

    @(negedge clk);
    // reset state, and split override while in reset
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_tgt", int'(tgt3), 0);
    chk("rst_sel", int'(sel3), 0);
    chk("rst_err", int'(err3), 0);
    chk("rst_busy", int'(busy3), 0);
    split = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_split_tgt", int'(tgt3), 4);
    chk("rst_split_sel", int'(sel3), 2);
    split = 1'b0;
    idle();

    // table-driven address vectors, each followed by a full data frame
    foreach (vecs[i]) begin
      send_addr(vecs[i].addr);
      chk("vec_tgt3", int'(tgt3), vecs[i].tgt3);
      chk("vec_sel3", int'(sel3), vecs[i].sel3);
      chk("vec_err3", int'(err3), vecs[i].err3);
      chk("vec_busy3", int'(busy3), int'(vecs[i].tgt3 != 0));
      chk("vec_tgt4", int'(tgt4), vecs[i].tgt4);
      chk("vec_sel4", int'(sel4), vecs[i].sel4);
      chk("vec_err4", int'(err4), vecs[i].err4);
      idle();
      chk("vec_err3_pulse", int'(err3), 0);
      chk("vec_err4_pulse", int'(err4), 0);
      if (vecs[i].tgt3 != 0 || vecs[i].tgt4 != 0) begin
        send_data(DATA_W - 1);
        chk("frame_hold3", int'(tgt3), vecs[i].tgt3);
        send_data(1);
        chk("frame_rel3", int'(tgt3), 0);
        chk("frame_rel_busy3", int'(busy3), 0);
        chk("frame_rel4", int'(tgt4), 0);
      end
    end

    // partial address discard
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("discard_err", int'(err3), 0);
    chk("discard_busy", int'(busy3), 0);
    send_addr(16'h0000);
    chk("discard_tgt", int'(tgt3), 1);
    send_data(DATA_W);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    send_addr(16'h4000);
    chk("discard2_tgt", int'(tgt3), 2);
    send_data(DATA_W);

    // split override while holding target 0; frame count survives
    send_addr(16'h0123);
    send_data(3);
    split = 1'b1;
    idle();
    chk("split_tgt", int'(tgt3), 4);
    chk("split_sel", int'(sel3), 2);
    chk("split_busy", int'(busy3), 1);
    split = 1'b0;
    idle();
    chk("unsplit_tgt", int'(tgt3), 1);
    chk("unsplit_sel", int'(sel3), 0);
    send_data(4);
    chk("split_cnt_hold", int'(tgt3), 1);
    send_data(1);
    chk("split_cnt_rel", int'(tgt3), 0);

    // address bit during hold restarts the frame count
    send_addr(16'h4ABC);
    send_data(6);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    send_data(DATA_W - 1);
    chk("restart_hold", int'(tgt3), 2);
    send_data(1);
    chk("restart_rel", int'(tgt3), 0);
    send_addr(16'h8001);
    chk("restart_next", int'(tgt3), 4);
    send_data(DATA_W);

    // reset mid-frame
    send_addr(16'h8000);
    send_data(4);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("midrst_tgt", int'(tgt3), 0);
    chk("midrst_sel", int'(sel3), 0);
    chk("midrst_busy", int'(busy3), 0);
    chk("midrst_tgt4", int'(tgt4), 0);

    // reset coinciding with the last address bit of a missing address
    for (int i = 0; i < ADDR_W - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("lastbit_rst_err", int'(err3), 0);
    send_addr(16'h4ABC);
    chk("after_rst_tgt", int'(tgt3), 2);
    send_data(DATA_W);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit r, v, md, b;
      r = ($urandom_range(0, 199) == 0);
      split = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      if (m_tgt[0] < 0) md = ($urandom_range(0, 19) == 0);
      else              md = ($urandom_range(0, 9) != 0);
      if (!v) md = 1'b1;
      b = 1'(($urandom_range(0, 1)));
      step(r, v, md, b);
    end
    split = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
